// File: rtl/dpe_pkg.sv
// -----------------------------------------------------------------------------
// dpe_pkg
// Shared constants for the DPE result collector slice: default widths, the
// int8 saturation bounds and the helper that builds the round-half-up
// constant used by requantization.
// No ports (package).
// -----------------------------------------------------------------------------
package dpe_pkg;

  // Default geometry of the result path.
  localparam int DEF_DATAW = 512;
  localparam int DEF_LANES = 64;
  localparam int DEF_IPREC = 8;
  localparam int DEF_OPREC = 32;

  // Saturation bounds of one output element.
  localparam int INT8_MAX = 32'sd127;
  localparam int INT8_MIN = -32'sd128;

  // Rounding constant added before the arithmetic right shift: 2^(shift-1).
  function automatic longint rnd_const(input int shift);
    return 64'sd1 <<< (shift - 32'sd1);
  endfunction

endpackage : dpe_pkg

// File: rtl/vector_fifo.sv
// -----------------------------------------------------------------------------
// vector_fifo
// Synchronous first-word-fall-through FIFO for packed output vectors.
// A push into a full FIFO is accepted only if a pop happens in the same
// cycle; otherwise the vector is dropped and o_drop pulses for that cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push/i_data  write request and vector
//   i_ready        downstream ready; pop = o_valid && i_ready
//   o_valid/o_data head entry valid and head entry
//   o_count        occupancy
//   o_almost_full  registered (o_count >= FIFO_DEPTH-1)
//   o_drop         combinational pulse: push refused because FIFO was full
// -----------------------------------------------------------------------------
module vector_fifo
  import dpe_pkg::*;
#(
  parameter int DATAW      = DEF_DATAW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_push,
  input  logic [DATAW-1:0]                   i_data,
  input  logic                               i_ready,
  output logic                               o_valid,
  output logic [DATAW-1:0]                   o_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_almost_full,
  output logic                               o_drop
);

  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] CNT_AF   = CNTW'(FIFO_DEPTH - 1);

  logic [DATAW-1:0] mem_q [FIFO_DEPTH];
  logic [DATAW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             valid_q, valid_d;
  logic             af_q, af_d;
  logic             pop_s, full_s, wr_s, drop_s;

  // Next-state computation for storage, pointers, occupancy and status flags.
  always_comb begin
    pop_s  = valid_q & i_ready;
    full_s = (count_q == CNT_FULL);
    wr_s   = i_push & (~full_s | pop_s);
    drop_s = i_push & full_s & ~pop_s;

    mem_d = mem_q;
    if (wr_s) begin
      mem_d[wr_ptr_q] = i_data;
    end else begin
      mem_d = mem_q;
    end

    if (wr_s) begin
      if (wr_ptr_q == PTR_LAST) wr_ptr_d = {PW{1'b0}};
      else                      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      if (rd_ptr_q == PTR_LAST) rd_ptr_d = {PW{1'b0}};
      else                      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    // Flags are registered from the next occupancy so they track o_count exactly.
    valid_d = (count_d != {CNTW{1'b0}});
    af_d    = (count_d >= CNT_AF);
  end

  // State registers with asynchronous clear of every entry and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {DATAW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CNTW{1'b0}};
      valid_q  <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      af_q     <= af_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_data        = mem_q[rd_ptr_q];
  assign o_count       = count_q;
  assign o_almost_full = af_q;
  assign o_drop        = drop_s;

endmodule : vector_fifo

// File: rtl/dpe_result_collector.sv
// -----------------------------------------------------------------------------
// dpe_result_collector
// Sums CHUNKS consecutive signed DPE results into one element, requantizes it
// to a saturated int8 with round-half-up, packs OUT_LANES elements into one
// vector and queues finished vectors in a small FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid/i_result  DPE result stream (no backpressure)
//   i_clear           synchronous abort of the partially built vector
//   o_valid/o_data    FIFO head vector, popped on o_valid && i_ready
//   i_ready           downstream ready
//   o_count           FIFO occupancy
//   o_almost_full     stall request toward the DPE issuer
//   o_overflow        sticky: a finished vector was dropped (reset-only clear)
// -----------------------------------------------------------------------------
module dpe_result_collector
  import dpe_pkg::*;
#(
  parameter int OPREC      = DEF_OPREC,
  parameter int IPREC      = DEF_IPREC,
  parameter int OUT_LANES  = DEF_LANES,
  parameter int DATAW      = DEF_DATAW,
  parameter int CHUNKS     = 4,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  input  logic signed [OPREC-1:0]           i_result,
  input  logic                              i_clear,
  output logic                              o_valid,
  output logic [DATAW-1:0]                  o_data,
  input  logic                              i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic                              o_almost_full,
  output logic                              o_overflow
);

  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LW = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
  localparam logic [CW-1:0] CHUNK_LAST = CW'(CHUNKS - 1);
  localparam logic [LW-1:0] LANE_LAST  = LW'(OUT_LANES - 1);

  // Requantization runs one bit wider than the accumulator so the rounding
  // add can never wrap.
  localparam longint                RND_L   = rnd_const(SHIFT);
  localparam logic signed [OPREC:0] RND     = RND_L[OPREC:0];
  localparam logic signed [OPREC:0] SAT_MAX = (OPREC+1)'(INT8_MAX);
  localparam logic signed [OPREC:0] SAT_MIN = (OPREC+1)'(INT8_MIN);

  logic signed [OPREC-1:0] acc_q, acc_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [IPREC-1:0]        q_q, q_d;
  logic                    q_valid_q, q_valid_d;
  logic [DATAW-1:0]        pack_q, pack_d;
  logic                    push_q, push_d;
  logic                    overflow_q, overflow_d;

  logic signed [OPREC-1:0] sum_s;
  logic signed [OPREC:0]   rounded_s;
  logic signed [OPREC:0]   shifted_s;
  logic [IPREC-1:0]        q_s;
  logic                    fifo_push_s;
  logic                    fifo_drop_s;

  // Element sum and its rounded, shifted, saturated int8 value.
  always_comb begin
    // Chunk 0 starts a fresh element, so the stale accumulator is ignored.
    if (chunk_q == {CW{1'b0}}) begin
      sum_s = i_result;
    end else begin
      sum_s = acc_q + i_result;
    end
    rounded_s = {sum_s[OPREC-1], sum_s} + RND;
    shifted_s = rounded_s >>> SHIFT;
    if (shifted_s > SAT_MAX) begin
      q_s = SAT_MAX[IPREC-1:0];
    end else if (shifted_s < SAT_MIN) begin
      q_s = SAT_MIN[IPREC-1:0];
    end else begin
      q_s = shifted_s[IPREC-1:0];
    end
  end

  // Accumulate / pack pipeline: result -> q register -> pack lane -> push.
  always_comb begin
    acc_d      = acc_q;
    chunk_d    = chunk_q;
    lane_d     = lane_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    pack_d     = pack_q;
    push_d     = 1'b0;
    overflow_d = overflow_q | fifo_drop_s;

    if (i_clear) begin
      // Abort wins over a same-cycle result; FIFO contents are untouched.
      acc_d     = {OPREC{1'b0}};
      chunk_d   = {CW{1'b0}};
      lane_d    = {LW{1'b0}};
      q_valid_d = 1'b0;
      push_d    = 1'b0;
    end else begin
      if (i_valid) begin
        acc_d = sum_s;
        if (chunk_q == CHUNK_LAST) begin
          chunk_d   = {CW{1'b0}};
          q_d       = q_s;
          q_valid_d = 1'b1;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end else begin
        acc_d = acc_q;
      end

      if (q_valid_q) begin
        pack_d[lane_q*IPREC +: IPREC] = q_q;
        if (lane_q == LANE_LAST) begin
          lane_d = {LW{1'b0}};
          push_d = 1'b1;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end else begin
        lane_d = lane_q;
      end
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= {OPREC{1'b0}};
      chunk_q    <= {CW{1'b0}};
      lane_q     <= {LW{1'b0}};
      q_q        <= {IPREC{1'b0}};
      q_valid_q  <= 1'b0;
      pack_q     <= {DATAW{1'b0}};
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      chunk_q    <= chunk_d;
      lane_q     <= lane_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      pack_q     <= pack_d;
      push_q     <= push_d;
      overflow_q <= overflow_d;
    end
  end

  // A push already scheduled is cancelled by a clear in the same cycle.
  assign fifo_push_s = push_q & ~i_clear;

  vector_fifo #(
    .DATAW      (DATAW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (fifo_push_s),
    .i_data        (pack_q),
    .i_ready       (i_ready),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .o_count       (o_count),
    .o_almost_full (o_almost_full),
    .o_drop        (fifo_drop_s)
  );

  assign o_overflow = overflow_q;

endmodule : dpe_result_collector

// File: tb/tb_dpe_result_collector.sv
// -----------------------------------------------------------------------------
// tb_dpe_result_collector
// Randomized self-checking bench. Expected vectors come from a behavioural
// model: per lane, plain integer sum of CHUNKS results wrapped to 32 bits,
// round-half-up divide by 2^SHIFT, clamp to int8.
// -----------------------------------------------------------------------------
module tb_dpe_result_collector;

  localparam int OPREC      = 32;
  localparam int IPREC      = 8;
  localparam int OUT_LANES  = 64;
  localparam int DATAW      = 512;
  localparam int CHUNKS     = 4;
  localparam int SHIFT      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNTW       = $clog2(FIFO_DEPTH + 1);
  localparam int NRES       = OUT_LANES * CHUNKS;

  logic                    clk;
  logic                    rst_n;
  logic                    i_valid;
  logic signed [OPREC-1:0] i_result;
  logic                    i_clear;
  logic                    o_valid;
  logic [DATAW-1:0]        o_data;
  logic                    i_ready;
  logic [CNTW-1:0]         o_count;
  logic                    o_almost_full;
  logic                    o_overflow;

  int checks;
  int failures;
  int vres [NRES];
  logic [DATAW-1:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dpe_result_collector #(
    .OPREC(OPREC), .IPREC(IPREC), .OUT_LANES(OUT_LANES), .DATAW(DATAW),
    .CHUNKS(CHUNKS), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_result(i_result),
    .i_clear(i_clear), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_count(o_count), .o_almost_full(o_almost_full), .o_overflow(o_overflow)
  );

  // ---------------- reference model ----------------
  function automatic logic [IPREC-1:0] ref_elem(input longint total);
    longint wrapped;
    longint scaled;
    logic [IPREC-1:0] r;
    wrapped = longint'(int'(total));
    scaled  = (wrapped + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    if (scaled > 127)       r = 8'h7F;
    else if (scaled < -128) r = 8'h80;
    else                    r = scaled[IPREC-1:0];
    return r;
  endfunction

  function automatic logic [DATAW-1:0] ref_vector();
    logic [DATAW-1:0] v;
    longint total;
    v = '0;
    for (int l = 0; l < OUT_LANES; l++) begin
      total = 0;
      for (int c = 0; c < CHUNKS; c++) total += longint'(vres[l*CHUNKS + c]);
      v[l*IPREC +: IPREC] = ref_elem(total);
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_random(input bit wide);
    for (int i = 0; i < NRES; i++) begin
      if (wide) vres[i] = int'($urandom);
      else      vres[i] = int'($urandom_range(4000, 0)) - 2000;
    end
  endtask

  task automatic send_results(input int first, input int last, input int gap_pct);
    for (int i = first; i <= last; i++) begin
      i_valid  = 1'b1;
      i_result = vres[i];
      @(posedge clk); #1;
      i_valid = 1'b0;
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_vector(input int gap_pct);
    send_results(0, NRES - 1, gap_pct);
    exp_q.push_back(ref_vector());
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (o_valid !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1; i_result = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", o_data); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", o_count); end
    checks++; if (o_almost_full !== 1'b0) begin failures++; $display("FAIL reset_af: got %b want 0", o_almost_full); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rounding();
    logic [DATAW-1:0] exp;
    fill_random(1'b0);
    vres[0] = 100; vres[1] = 200; vres[2] = 300; vres[3] = 424;
    send_vector(0);
    wait_valid(10);
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL rounding_valid: got %b want 1", o_valid); end
    checks++; if (o_data[7:0] !== 8'h04) begin failures++; $display("FAIL rounding_lane0: got %h want 04", o_data[7:0]); end
    checks++; if (o_data !== exp) begin failures++; $display("FAIL rounding_vector: got %h want %h", o_data, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [DATAW-1:0] exp;
    logic [7:0] want [5];
    fill_random(1'b0);
    for (int c = 0; c < CHUNKS; c++) begin
      vres[0*CHUNKS + c] = 10000;
      vres[1*CHUNKS + c] = -10000;
      vres[2*CHUNKS + c] = 96;
      vres[3*CHUNKS + c] = -96;
      vres[4*CHUNKS + c] = 0;
    end
    vres[4*CHUNKS] = 2147483647; vres[4*CHUNKS + 1] = 1;   // wraps to -2^31
    want[0] = 8'h7F; want[1] = 8'h80; want[2] = 8'h02; want[3] = 8'hFF; want[4] = 8'h80;
    send_vector(30);
    wait_valid(10);
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL sat_valid: got %b want 1", o_valid); end
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (o_data[l*8 +: 8] !== want[l]) begin
        failures++; $display("FAIL sat_lane%0d: got %h want %h", l, o_data[l*8 +: 8], want[l]);
      end
    end
    checks++; if (o_data !== exp) begin failures++; $display("FAIL sat_vector: got %h want %h", o_data, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_vector();
    logic [DATAW-1:0] fours;
    logic [DATAW-1:0] exp;
    fours = {OUT_LANES{8'h04}};
    for (int i = 0; i < NRES; i++) vres[i] = 256;
    send_vector(0);
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL lat_edge0: got %b want 0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL lat_edge1: got %b want 0", o_valid); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL lat_edge2: got %b want 1", o_valid); end
    checks++; if (o_data !== fours) begin failures++; $display("FAIL full_data: got %h want %h", o_data, fours); end
    checks++; if (o_data !== exp) begin failures++; $display("FAIL full_model: got %h want %h", o_data, exp); end
    @(posedge clk); #1;
    checks++; if (o_count !== '0) begin failures++; $display("FAIL full_popped: got %0d want 0", o_count); end
  endtask

  task automatic test_random();
    logic [DATAW-1:0] exp;
    for (int v = 0; v < 3; v++) begin
      fill_random(v[0]);
      send_vector(40);
      wait_valid(10);
      exp = exp_q.pop_front();
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL random%0d_valid: got %b want 1", v, o_valid); end
      checks++; if (o_data !== exp) begin failures++; $display("FAIL random%0d_data: got %h want %h", v, o_data, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_with_pop();
    logic [DATAW-1:0] exp;
    test_reset();
    i_ready = 1'b0;
    for (int v = 0; v < FIFO_DEPTH; v++) begin
      fill_random(1'b1);
      send_vector(0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_count !== CNTW'(FIFO_DEPTH)) begin failures++; $display("FAIL fwp_fill: got %0d want %0d", o_count, FIFO_DEPTH); end
    fill_random(1'b0);
    send_vector(0);
    @(posedge clk); #1;
    checks++; if (o_data !== exp_q[0]) begin failures++; $display("FAIL fwp_head: got %h want %h", o_data, exp_q[0]); end
    void'(exp_q.pop_front());
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    checks++; if (o_count !== CNTW'(FIFO_DEPTH)) begin failures++; $display("FAIL fwp_count: got %0d want %0d", o_count, FIFO_DEPTH); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL fwp_ovf: got %b want 0", o_overflow); end
    i_ready = 1'b1;
    for (int v = 0; v < FIFO_DEPTH; v++) begin
      wait_valid(5);
      exp = exp_q.pop_front();
      checks++; if (o_data !== exp || o_valid !== 1'b1) begin failures++; $display("FAIL fwp_drain%0d: got %h want %h", v, o_data, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [DATAW-1:0] exp;
    test_reset();
    i_ready = 1'b0;
    for (int v = 0; v < FIFO_DEPTH; v++) begin
      fill_random(v[0]);
      send_vector(0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_count !== CNTW'(v + 1)) begin failures++; $display("FAIL bp_count%0d: got %0d want %0d", v, o_count, v + 1); end
      checks++;
      if (o_almost_full !== (v + 1 >= FIFO_DEPTH - 1)) begin
        failures++; $display("FAIL bp_af%0d: got %b want %b", v, o_almost_full, (v + 1 >= FIFO_DEPTH - 1));
      end
    end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_early: got %b want 0", o_overflow); end
    fill_random(1'b1);
    send_vector(0);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf: got %b want 1", o_overflow); end
    checks++; if (o_count !== CNTW'(FIFO_DEPTH)) begin failures++; $display("FAIL bp_count_full: got %0d want %0d", o_count, FIFO_DEPTH); end
    checks++; if (o_data !== exp_q[0]) begin failures++; $display("FAIL bp_head: got %h want %h", o_data, exp_q[0]); end
    i_ready = 1'b1;
    for (int v = 0; v < FIFO_DEPTH; v++) begin
      wait_valid(5);
      exp = exp_q.pop_front();
      checks++; if (o_data !== exp || o_valid !== 1'b1) begin failures++; $display("FAIL bp_drain%0d: got %h want %h", v, o_data, exp); end
      @(posedge clk); #1;
    end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky: got %b want 1", o_overflow); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL bp_empty: got %0d want 0", o_count); end
  endtask

  task automatic test_clear();
    logic [DATAW-1:0] exp;
    i_ready = 1'b1;
    fill_random(1'b0);
    send_results(0, 10 * CHUNKS + 1, 0);   // 10 lanes plus two chunks
    i_clear = 1'b1; i_valid = 1'b1; i_result = 32'sd12345;
    @(posedge clk); #1;
    i_clear = 1'b0; i_valid = 1'b0;
    fill_random(1'b1);
    send_vector(20);
    wait_valid(10);
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL clear_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== exp) begin failures++; $display("FAIL clear_data: got %h want %h", o_data, exp); end
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0 || o_count !== '0) begin failures++; $display("FAIL clear_single: got valid=%b count=%0d want 0/0", o_valid, o_count); end
  endtask

  task automatic test_reset_midvector();
    logic [DATAW-1:0] exp;
    i_ready = 1'b0;
    fill_random(1'b1);
    send_vector(0);
    fill_random(1'b0);
    send_results(0, 99, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_count !== CNTW'(1)) begin failures++; $display("FAIL rst_pre_count: got %0d want 1", o_count); end
    i_valid = 1'b1; i_result = 32'sd777;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL rstmid_data: got %h want 0", o_data); end
    checks++; if (o_count !== '0) begin failures++; $display("FAIL rstmid_count: got %0d want 0", o_count); end
    checks++; if (o_almost_full !== 1'b0) begin failures++; $display("FAIL rstmid_af: got %b want 0", o_almost_full); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL rstmid_ovf: got %b want 0", o_overflow); end
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    i_ready = 1'b1;
    fill_random(1'b0);
    send_vector(10);
    wait_valid(10);
    exp = exp_q.pop_front();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL rstpost_valid: got %b want 1", o_valid); end
    checks++; if (o_data !== exp) begin failures++; $display("FAIL rstpost_data: got %h want %h", o_data, exp); end
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_rounding();
    test_saturation();
    test_full_vector();
    test_random();
    test_full_with_pop();
    test_backpressure();
    test_clear();
    test_reset_midvector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dpe_result_collector
